operand_stream_accumulator: RTL

- Sequential front-end that feeds the 16-bit carry-select adder from a stream of operands.
- Accepts a packet of NUM_OPS unsigned 16-bit operands over a valid/ready handshake.
- Accumulates the operands through one carry_select_adder instance, then presents the 16-bit wrapped sum and a sticky overflow flag on an output valid/ready handshake.
- Sits between an operand source (register file / test driver) and the result consumer.

---
 rtl/operand_stream_accumulator_pkg.sv | 13 +
 rtl/carry_select_adder.sv | 34 +++
 rtl/operand_stream_accumulator.sv | 101 ++++++++++
 3 files changed

// File: rtl/operand_stream_accumulator_pkg.sv
// Shared constants and state encoding for the operand stream accumulator
// and the carry-select adder it drives.
package operand_stream_accumulator_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_e;

endpackage

// File: rtl/carry_select_adder.sv
// 16-bit carry-select adder: 4-bit blocks each precompute both carry-in
// outcomes, and the rippling block carry selects between them.
module carry_select_adder
    import operand_stream_accumulator_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int BLK  = 4;
    localparam int NBLK = WIDTH / BLK;

    logic [NBLK:0] carry_s;

    assign carry_s[0] = cin;

    for (genvar g = 0; g < NBLK; g++) begin : g_blk
        logic [BLK:0] sum0_s;
        logic [BLK:0] sum1_s;

        assign sum0_s = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]};
        assign sum1_s = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]}
                      + {{BLK{1'b0}}, 1'b1};

        assign sum[g*BLK +: BLK] = carry_s[g] ? sum1_s[BLK-1:0] : sum0_s[BLK-1:0];
        assign carry_s[g+1]      = carry_s[g] ? sum1_s[BLK]     : sum0_s[BLK];
    end

    assign cout = carry_s[NBLK];

endmodule

// File: rtl/operand_stream_accumulator.sv
// Accumulates a packet of NUM_OPS unsigned operands through one carry-select
// adder and presents the wrapped sum plus sticky overflow on a valid/ready port.
module operand_stream_accumulator
    import operand_stream_accumulator_pkg::*;
#(
    parameter int NUM_OPS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_overflow,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OPS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e             state_r;
    state_e             state_nx_s;
    logic [WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]   acc_nx_s;
    logic               ovf_r;
    logic               ovf_nx_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nx_s;
    logic [WIDTH-1:0]   add_sum_s;
    logic               add_cout_s;

    carry_select_adder u_adder (
        .a    (acc_r),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    // Next-state and datapath update; in_ready is implied by ST_ACCUM here
    // because rst overrides everything in the register process anyway.
    always_comb begin
        state_nx_s = state_r;
        acc_nx_s   = acc_r;
        ovf_nx_s   = ovf_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            ST_ACCUM: begin
                if (in_valid) begin
                    acc_nx_s = add_sum_s;
                    ovf_nx_s = ovf_r | add_cout_s;
                    cnt_nx_s = cnt_r + CNT_ONE;
                    if (cnt_r == LAST_CNT) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_ACCUM;
                    end
                end else begin
                    state_nx_s = ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    acc_nx_s   = {WIDTH{1'b0}};
                    ovf_nx_s   = 1'b0;
                    cnt_nx_s   = {CNT_W{1'b0}};
                    state_nx_s = ST_ACCUM;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: begin
                state_nx_s = ST_ACCUM;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_ACCUM;
            acc_r   <= {WIDTH{1'b0}};
            ovf_r   <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            acc_r   <= acc_nx_s;
            ovf_r   <= ovf_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    assign in_ready     = (state_r == ST_ACCUM) && !rst;
    assign out_valid    = (state_r == ST_DONE);
    assign out_sum      = acc_r;
    assign out_overflow = ovf_r;
    assign out_count    = cnt_r;

endmodule
